// File: rtl/delta_stage.sv
// delta_stage: joins forward and error accumulator streams,
// computes saturated per-lane deltas, and broadcasts them.
module delta_stage #(
  parameter int NP    = 5,
  parameter int NN    = 7,
  parameter int NC    = 6,
  parameter int WF    = 4,
  parameter int NO    = 2,
  parameter int DEPTH = 2,
  parameter int CW    = 16,
  localparam int WA1  = $clog2(NP) - 1 + WF,
  localparam int WA2  = $clog2(NN) - 1 + WF
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iMode,
  input  logic              iValid_AS_Accum1,
  output logic              oReady_AS_Accum1,
  input  logic [NC*WA1-1:0] iData_AS_Accum1,
  input  logic              iValid_AS_Accum2,
  output logic              oReady_AS_Accum2,
  input  logic [NC*WA2-1:0] iData_AS_Accum2,
  output logic [NO-1:0]     oValid_BM_Delta,
  input  logic [NO-1:0]     iReady_BM_Delta,
  output logic [NC*WF-1:0]  oData_BM_Delta,
  input  logic              iSatClr,
  output logic [CW-1:0]     oSatCount
);

  localparam int W    = ((WA1 > WA2) ? WA1 : WA2) + 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int PCW  = $clog2(NC + 1);

  localparam logic signed [W-1:0] LMAX =
    W'((1 << (WF - 1)) - 1);
  localparam logic signed [W-1:0] LMIN = ~LMAX;

  logic [NC*WF-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CNTW-1:0]  r_cnt;
  logic [NO-1:0]    r_done;
  logic [CW-1:0]    r_sat;

  logic             w_full;
  logic             w_empty;
  logic             w_fire;
  logic             w_pop;
  logic [NO-1:0]    w_take;
  logic [NC-1:0]    w_sat;
  logic [NC*WF-1:0] w_res;
  logic [PCW-1:0]   w_pc;
  logic [CW-1:0]    w_base;
  logic [PCW-1:0]   w_add;
  logic [CW:0]      w_sum;
  logic [CW-1:0]    w_sat_nxt;

  assign w_full  = (r_cnt == CNTW'(DEPTH));
  assign w_empty = (r_cnt == '0);

  assign oReady_AS_Accum1 =
    iRST & iValid_AS_Accum2 & ~w_full;
  assign oReady_AS_Accum2 =
    iRST & iValid_AS_Accum1 & ~w_full;

  assign w_fire = iRST & iValid_AS_Accum1 &
                  iValid_AS_Accum2 & ~w_full;

  // Per-lane gated delta or difference, then clip to WF bits
  for (genvar gi = 0; gi < NC; gi++) begin : g_lane
    logic signed [WA1-1:0] w_a1n;
    logic signed [WA2-1:0] w_a2n;
    logic signed [W-1:0]   w_a1;
    logic signed [W-1:0]   w_a2;
    logic signed [W-1:0]   w_r;
    logic                  w_gate;

    assign w_a1n = iData_AS_Accum1[gi*WA1 +: WA1];
    assign w_a2n = iData_AS_Accum2[gi*WA2 +: WA2];
    assign w_a1  = {{(W-WA1){w_a1n[WA1-1]}}, w_a1n};
    assign w_a2  = {{(W-WA2){w_a2n[WA2-1]}}, w_a2n};

    assign w_gate = (w_a1 > LMAX) | w_a1[W-1];
    assign w_r    = iMode ? (w_gate ? '0 : w_a2)
                          : (w_a1 - w_a2);

    assign w_sat[gi] = (w_r > LMAX) | (w_r < LMIN);
    assign w_res[gi*WF +: WF] =
      (w_r > LMAX) ? LMAX[WF-1:0] :
      (w_r < LMIN) ? LMIN[WF-1:0] :
                     w_r[WF-1:0];
  end

  // Count clipped lanes in this token
  always_comb begin
    w_pc = '0;
    for (int i = 0; i < NC; i++) begin
      w_pc = w_pc + PCW'(w_sat[i]);
    end
  end

  // Clear restarts from zero; adds clamp at all-ones
  always_comb begin
    w_base    = iSatClr ? '0 : r_sat;
    w_add     = w_fire ? w_pc : '0;
    w_sum     = {1'b0, w_base} + (CW+1)'(w_add);
    w_sat_nxt = w_sum[CW] ? '1 : w_sum[CW-1:0];
  end

  assign oValid_BM_Delta = {NO{~w_empty}} & ~r_done;
  assign w_take  = oValid_BM_Delta & iReady_BM_Delta;
  assign w_pop   = ~w_empty & (&(r_done | w_take));
  assign oData_BM_Delta = r_mem[r_rptr];
  assign oSatCount      = r_sat;

  // FIFO storage needs no reset; occupancy is in r_cnt
  always_ff @(posedge iCLK) begin
    if (w_fire) r_mem[r_wptr] <= w_res;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_fire) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + CNTW'(w_fire) - CNTW'(w_pop);
    end
  end

  // Per-consumer taken flags, cleared when the head pops
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_done <= '0;
    end else if (w_pop) begin
      r_done <= '0;
    end else begin
      r_done <= r_done | w_take;
    end
  end

  // Saturation event counter
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) r_sat <= '0;
    else       r_sat <= w_sat_nxt;
  end

endmodule

// File: tb/tb_delta_stage.sv
// tb_delta_stage: scoreboard bench for delta_stage
// with directed vectors and per-consumer queues.
module tb_delta_stage;

  localparam int NC = 6;
  localparam int WF = 4;
  localparam int WA = 6;
  localparam int NO = 3;
  localparam int CW = 4;

  logic              iCLK = 0;
  logic              iRST;
  logic              iMode;
  logic              iV1;
  logic              oR1;
  logic [NC*WA-1:0]  iD1;
  logic              iV2;
  logic              oR2;
  logic [NC*WA-1:0]  iD2;
  logic [NO-1:0]     oV;
  logic [NO-1:0]     iRdy;
  logic [NC*WF-1:0]  oD;
  logic              iSatClr;
  logic [CW-1:0]     oSat;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [NC*WF-1:0] q [NO][$];
  int tq [$];

  delta_stage #(
    .NP(5), .NN(7), .NC(NC), .WF(WF),
    .NO(NO), .DEPTH(2), .CW(CW)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .iMode(iMode),
    .iValid_AS_Accum1(iV1),
    .oReady_AS_Accum1(oR1),
    .iData_AS_Accum1(iD1),
    .iValid_AS_Accum2(iV2),
    .oReady_AS_Accum2(oR2),
    .iData_AS_Accum2(iD2),
    .oValid_BM_Delta(oV),
    .iReady_BM_Delta(iRdy),
    .oData_BM_Delta(oD),
    .iSatClr(iSatClr),
    .oSatCount(oSat)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [NC*WA-1:0] mk(
    int v0, int v1, int v2, int v3, int v4, int v5);
    logic [NC*WA-1:0] r;
    r[0*WA +: WA] = v0[WA-1:0];
    r[1*WA +: WA] = v1[WA-1:0];
    r[2*WA +: WA] = v2[WA-1:0];
    r[3*WA +: WA] = v3[WA-1:0];
    r[4*WA +: WA] = v4[WA-1:0];
    r[5*WA +: WA] = v5[WA-1:0];
    return r;
  endfunction

  function automatic logic [NC*WF-1:0] mkf(
    int v0, int v1, int v2, int v3, int v4, int v5);
    logic [NC*WF-1:0] r;
    r[0*WF +: WF] = v0[WF-1:0];
    r[1*WF +: WF] = v1[WF-1:0];
    r[2*WF +: WF] = v2[WF-1:0];
    r[3*WF +: WF] = v3[WF-1:0];
    r[4*WF +: WF] = v4[WF-1:0];
    r[5*WF +: WF] = v5[WF-1:0];
    return r;
  endfunction

  function automatic logic [NC*WA-1:0] mkall(int v);
    return mk(v, v, v, v, v, v);
  endfunction

  function automatic logic [NC*WF-1:0] mkfall(int v);
    return mkf(v, v, v, v, v, v);
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every consumer take is matched to its queue
  always @(negedge iCLK) begin
    logic [NC*WF-1:0] e;
    cyc++;
    for (int k = 0; k < NO; k++) begin
      if (oV[k] && iRdy[k]) begin
        checks++;
        if (q[k].size() == 0) begin
          fails++;
          $display("FAIL take%0d unexpected got=%h",
                   k, oD);
        end else begin
          e = q[k].pop_front();
          if (oD !== e) begin
            fails++;
            $display("FAIL take%0d data got=%h exp=%h",
                     k, oD, e);
          end
        end
        if (k == 0) tq.push_back(cyc);
      end
    end
  end

  task automatic send(bit m, logic [NC*WA-1:0] a1,
                      logic [NC*WA-1:0] a2,
                      logic [NC*WF-1:0] e);
    bit ok;
    iMode = m;
    iD1   = a1;
    iD2   = a2;
    iV1   = 1'b1;
    iV2   = 1'b1;
    for (int k = 0; k < NO; k++) q[k].push_back(e);
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge iCLK);
      if (oR1 && oR2) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL send timeout got=0 exp=1");
      iV1 = 1'b0;
      iV2 = 1'b0;
    end
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle();
    iV1 = 1'b0;
    iV2 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    for (int t = 0; t < 100; t++) begin
      n = 0;
      for (int k = 0; k < NO; k++) n += q[k].size();
      if (n == 0) break;
      @(negedge iCLK);
    end
    chk("drain_left", n, 0);
  endtask

  initial begin
    iRST = 0; iMode = 0; iV1 = 1; iV2 = 1;
    iD1 = '0; iD2 = '0; iRdy = '1; iSatClr = 0;
    repeat (2) @(negedge iCLK);
    chk("rst_valid", oV, 0);
    chk("rst_rdy1", oR1, 0);
    chk("rst_rdy2", oR2, 0);
    chk("rst_sat", oSat, 0);
    @(posedge iCLK); #1;
    iV1 = 0; iV2 = 0; iRST = 1;

    // Hidden mode gating
    send(1, mk(3, 8, -1, 0, 7, 1), mk(5, 5, 5, -3, -8, 2),
         mkf(5, 0, 0, -3, -8, 2));
    idle();
    chk("hid_sat", oSat, 0);
    // Output mode with clipping on four lanes
    send(0, mk(7, -8, 2, 0, 31, -32),
         mk(-20, 20, 5, 0, -32, 31),
         mkf(7, -8, -3, 0, 7, -8));
    idle();
    chk("out_sat", oSat, 4);
    send(0, mk(1, 2, 3, 4, 5, 6), mkall(1),
         mkf(0, 1, 2, 3, 4, 5));
    idle();
    chk("out_small_sat", oSat, 4);
    drain();

    // Consumer 2 stalls: third token must wait
    @(posedge iCLK); #1;
    iRdy = 3'b011;
    send(0, mkall(1), mkall(0), mkfall(1));
    send(0, mkall(2), mkall(0), mkfall(2));
    fork
      send(0, mkall(3), mkall(0), mkfall(3));
      begin
        repeat (4) begin
          @(negedge iCLK);
          chk("stall_rdy1", oR1, 0);
          chk("stall_rdy2", oR2, 0);
          chk("stall_valid", oV, 3'b100);
        end
        @(posedge iCLK); #1;
        iRdy = 3'b111;
      end
    join
    idle();
    drain();

    // Only Accum1 valid: nothing consumed
    @(posedge iCLK); #1;
    iMode = 0; iD1 = mkall(-2); iD2 = mkall(1);
    iV1 = 1;
    repeat (5) begin
      @(negedge iCLK);
      chk("a1only_rdy1", oR1, 0);
      chk("a1only_valid", oV, 0);
    end
    @(posedge iCLK); #1;
    iV2 = 1;
    for (int k = 0; k < NO; k++) q[k].push_back(mkfall(-3));
    @(negedge iCLK);
    chk("join_rdy1", oR1, 1);
    chk("join_valid_pre", oV, 0);
    @(posedge iCLK); #1;
    idle();
    @(negedge iCLK);
    chk("join_valid_post", oV, 3'b111);
    drain();

    // Ten back-to-back tokens
    @(posedge iCLK); #1;
    tq.delete();
    for (int i = 0; i < 10; i++)
      send(0, mkall(i - 4), mkall(0), mkfall(i - 4));
    idle();
    drain();
    chk("b2b_count", tq.size(), 10);
    if (tq.size() == 10)
      chk("b2b_span", tq[9] - tq[0], 9);

    // Saturation counter clear and clamp
    @(posedge iCLK); #1;
    iSatClr = 1;
    @(posedge iCLK); #1;
    iSatClr = 0;
    chk("satclr", oSat, 0);
    for (int i = 0; i < 5; i++) begin
      send(0, mk(7, -8, 2, 0, 31, -32),
           mk(-20, 20, 5, 0, -32, 31),
           mkf(7, -8, -3, 0, 7, -8));
      chk("sat_accum", oSat, (i < 3) ? 4 * (i + 1) : 15);
    end
    iSatClr = 1;
    send(0, mk(7, -8, 0, 0, 0, 0),
         mk(-20, 20, 0, 0, 0, 0),
         mkf(7, -8, 0, 0, 0, 0));
    iSatClr = 0;
    idle();
    chk("satclr_fire", oSat, 2);
    drain();

    // Reset with tokens buffered
    @(posedge iCLK); #1;
    iRdy = 3'b000;
    send(0, mkall(1), mkall(0), mkfall(1));
    send(0, mkall(2), mkall(0), mkfall(2));
    iD1 = mkall(3);
    @(negedge iCLK);
    chk("pre_rst_valid", oV, 3'b111);
    chk("pre_rst_full", oR1, 0);
    @(posedge iCLK); #1;
    iRST = 0;
    #1;
    chk("mid_rst_valid", oV, 0);
    chk("mid_rst_rdy1", oR1, 0);
    chk("mid_rst_rdy2", oR2, 0);
    chk("mid_rst_sat", oSat, 0);
    for (int k = 0; k < NO; k++) q[k].delete();
    @(posedge iCLK); #1;
    idle();
    iRST = 1;
    iRdy = 3'b111;
    @(negedge iCLK);
    chk("post_rst_valid", oV, 0);
    @(posedge iCLK); #1;
    send(0, mkall(5), mkall(2), mkfall(3));
    idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/delta_stage.md
Name: delta_stage

Overview:
- Next-generation error-delta element for the backprop datapath.
- Joins the forward-accumulator stream (Accum1) with the back-propagated error stream (Accum2).
- Per channel, computes either a hidden-layer gated delta or an output-layer difference, then saturates to WF bits.
- Buffers results in a small FIFO and broadcasts each delta token to NO independent consumers; also counts saturation events.
- New versus the previous generation: runtime mode select, N-way fan-out, registered/buffered output, overflow-safe subtraction, saturation telemetry.

Parameters:
- NP, 5: fan-in of the forward layer; Accum1 lane width WA1 = $clog2(NP)-1+WF.
- NN, 7: fan-in of the error path; Accum2 lane width WA2 = $clog2(NN)-1+WF.
- NC, 6: channels (lanes) per token.
- WF, 4: output fixed-point lane width, signed.
- NO, 2: number of delta consumers, 1..8.
- DEPTH, 2: output FIFO depth, power of two, >= 2.
- CW, 16: saturation counter width.

Ports:
- iCLK  in  1  clock; all state on rising edge.
- iRST  in  1  asynchronous, active-low reset.
- iMode  in  1  1 = hidden (gated), 0 = output (difference); sampled on join fire.
- iValid_AS_Accum1  in  1  Accum1 token valid.
- oReady_AS_Accum1  out  1  Accum1 ready.
- iData_AS_Accum1  in  NC*WA1  Accum1 lanes; lane gi at [gi*WA1 +: WA1].
- iValid_AS_Accum2  in  1  Accum2 token valid.
- oReady_AS_Accum2  out  1  Accum2 ready.
- iData_AS_Accum2  in  NC*WA2  Accum2 lanes.
- oValid_BM_Delta  out  NO  per-consumer valid.
- iReady_BM_Delta  in  NO  per-consumer ready.
- oData_BM_Delta  out  NC*WF  FIFO head, shared by all consumers.
- iSatClr  in  1  synchronous clear of oSatCount.
- oSatCount  out  CW  saturated-lane count, sticks at all-ones.

Behaviour:
- Reset, asynchronous, while iRST = 0:
  - FIFO empty; all done flags 0; oSatCount 0.
  - oValid_BM_Delta = 0; both oReady = 0.
  - Reset mid-transfer discards all buffered tokens.
- Join:
  - full = (count == DEPTH).
  - oReady_AS_Accum1 = iRST & iValid_AS_Accum2 & ~full.
  - oReady_AS_Accum2 = iRST & iValid_AS_Accum1 & ~full.
  - fire = both valids & ~full & iRST; both inputs are consumed in the same cycle. No partial consumption.
- Lane arithmetic, combinational on fire:
  - a1 is sign-extended to W = max(WA1, WA2) + 1; a2 is sign-extended to W.
  - Hidden mode: r = (a1 > ONE or a1 < 0) ? 0 : a2, where ONE = 2^(WF-1) - 1.
  - Output mode: r = a1 - a2, computed in W bits, no wrap.
  - Saturation: r > 2^(WF-1)-1 gives 2^(WF-1)-1; r < -2^(WF-1) gives -2^(WF-1); otherwise r[WF-1:0].
  - Per-lane flag s_i = 1 when clipped.
- FIFO:
  - Result is written on fire; visible at the head the next cycle (latency 1).
  - Full throughput of 1 token/cycle when consumers keep up.
  - Simultaneous push and pop at full is not allowed (push is blocked by full); at count >= 1, push and pop together leave count unchanged.
- Broadcast:
  - oValid_BM_Delta[k] = ~empty & ~done[k].
  - Consumer k takes the token when oValid[k] & iReady[k]; done[k] is set, unless this is the final take.
  - pop occurs when every k is either done or taking this cycle; all done flags clear on pop.
  - Consumers may accept in any order and in different cycles.
  - oData_BM_Delta is stable until pop.
- Saturation counter:
  - On fire, add popcount(s); result clamps at 2^CW - 1.
  - iSatClr with no fire: counter becomes 0.
  - iSatClr together with fire: counter becomes popcount(s) of that token.

Test Plan:
- Hidden mode, NP=5, WF=4: a1 = 3, a2 = 5 -> delta lane = 5. a1 = 8 -> delta = 0. a1 = -1 -> delta = 0. oSatCount unchanged.
- Output mode, NN=7, WF=4: a1 = 7, a2 = -20 -> r = 27, saturates to 7, sat +1. a1 = -8, a2 = 20 -> -8, sat +1. a1 = 2, a2 = 5 -> -3.
- NO = 3, DEPTH = 2: consumer 2 holds ready low -> third input token stalls (oReady = 0). Consumers 0 and 1 each see exactly one valid beat per token. Raising ready 2 pops the token and the next token appears next cycle.
- Only Accum1 valid for 5 cycles -> no consumption and no FIFO change. Accum2 then arrives -> single fire, output valid 1 cycle later.
- All consumers always ready, 10 back-to-back tokens -> 10 outputs on consecutive cycles, in order.
- CW = 4, drive 16 saturating lanes -> count holds at 15. iSatClr together with a 2-lane-saturating fire -> 2. Reset asserted mid-stream -> valids drop immediately, FIFO empties.
